// File: rtl/safety_heartbeat_monitor.sv
// Heartbeat receiver: checks high/low phase windows, acknowledges valid periods and escalates repeated violations.
// Define SAFETY_HBMON_SYNC3_EN for a 3-flop input synchronizer (default 2-flop).
module safety_heartbeat_monitor #(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned HIGH_MIN   = 90,
  parameter int unsigned HIGH_MAX   = 110,
  parameter int unsigned LOW_MIN    = 90,
  parameter int unsigned LOW_MAX    = 115,
  parameter int unsigned STARTUP_TO = 1024,
  parameter int unsigned FAIL_LIMIT = 3,
  parameter int unsigned FB_LEN     = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic       clear_i,
  input  logic       hb_i,
  output logic       feedback_o,
  output logic       err_o,
  output logic [2:0] fault_code_o,
  output logic [3:0] err_cnt_o,
  output logic       fault_o
);

`ifdef SAFETY_HBMON_SYNC3_EN
  localparam int unsigned SYNC_N = 3;
`else
  localparam int unsigned SYNC_N = 2;
`endif

  localparam logic [CNT_W-1:0] ONE_C        = CNT_W'(1);
  localparam logic [CNT_W-1:0] HIGH_MIN_C   = CNT_W'(HIGH_MIN);
  localparam logic [CNT_W-1:0] HIGH_MAX_C   = CNT_W'(HIGH_MAX);
  localparam logic [CNT_W-1:0] LOW_MIN_C    = CNT_W'(LOW_MIN);
  localparam logic [CNT_W-1:0] LOW_MAX_C    = CNT_W'(LOW_MAX);
  localparam logic [CNT_W-1:0] STARTUP_TO_C = CNT_W'(STARTUP_TO);
  localparam logic [CNT_W-1:0] FB_LEN_C     = CNT_W'(FB_LEN);
  localparam logic [3:0]       FAIL_C       = 4'(FAIL_LIMIT);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_RISE,
    ST_HIGH,
    ST_LOW
  } state_e;

  typedef enum logic [2:0] {
    C_NONE       = 3'd0,
    C_SHORT_HIGH = 3'd1,
    C_LONG_HIGH  = 3'd2,
    C_SHORT_LOW  = 3'd3,
    C_LONG_LOW   = 3'd4,
    C_STARTUP    = 3'd5
  } code_e;

  state_e            state_q, state_d;
  logic [SYNC_N-1:0] sync_q;
  logic              s_prev_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [CNT_W-1:0]  fb_cnt_q, fb_cnt_d;
  logic              feedback_q;
  logic              err_q, err_d;
  code_e             code_q, code_d, det_code;
  logic [3:0]        err_cnt_q, err_cnt_d;
  logic              fault_q, fault_d;
  logic              s, rise, fall, valid;

  assign s       = sync_q[SYNC_N-1];
  assign rise    = s & ~s_prev_q;
  assign fall    = ~s & s_prev_q;
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + ONE_C;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    code_d    = code_q;
    err_cnt_d = err_cnt_q;
    fault_d   = fault_q;
    err_d     = 1'b0;
    det_code  = C_NONE;
    valid     = 1'b0;
    fb_cnt_d  = (fb_cnt_q != '0) ? fb_cnt_q - ONE_C : '0;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (en_i) state_d = ST_WAIT_RISE;
      end
      ST_WAIT_RISE: begin
        if (rise) begin
          state_d = ST_HIGH;
          cnt_d   = ONE_C;
        end else if (cnt_q == STARTUP_TO_C) begin
          det_code = C_STARTUP;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_HIGH: begin
        if (fall) begin
          if (cnt_q < HIGH_MIN_C) begin
            det_code = C_SHORT_HIGH;
          end else begin
            state_d = ST_LOW;
            cnt_d   = ONE_C;
          end
        end else if (s && cnt_q == HIGH_MAX_C) begin
          det_code = C_LONG_HIGH;
        end else if (s) begin
          cnt_d = cnt_inc;
        end
      end
      ST_LOW: begin
        if (rise) begin
          if (cnt_q < LOW_MIN_C) begin
            det_code = C_SHORT_LOW;
          end else begin
            valid   = 1'b1;
            state_d = ST_HIGH;
            cnt_d   = ONE_C;
          end
        end else if (!s && cnt_q == LOW_MAX_C) begin
          det_code = C_LONG_LOW;
        end else if (!s) begin
          cnt_d = cnt_inc;
        end
      end
    endcase

    // Priority: disable, then clear, then error, then valid period; clear always wipes status.
    if (!en_i) begin
      state_d  = ST_IDLE;
      cnt_d    = '0;
      fb_cnt_d = '0;
    end else if (clear_i) begin
      state_d = ST_WAIT_RISE;
      cnt_d   = '0;
    end else if (det_code != C_NONE) begin
      err_d     = 1'b1;
      code_d    = det_code;
      err_cnt_d = (err_cnt_q >= FAIL_C) ? FAIL_C : err_cnt_q + 4'd1;
      if (err_cnt_d == FAIL_C) fault_d = 1'b1;
      state_d = ST_WAIT_RISE;
      cnt_d   = '0;
    end else if (valid) begin
      err_cnt_d = '0;
      fb_cnt_d  = FB_LEN_C;
    end

    if (clear_i) begin
      fault_d   = 1'b0;
      code_d    = C_NONE;
      err_cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      sync_q     <= '0;
      s_prev_q   <= 1'b0;
      cnt_q      <= '0;
      fb_cnt_q   <= '0;
      feedback_q <= 1'b0;
      err_q      <= 1'b0;
      code_q     <= C_NONE;
      err_cnt_q  <= '0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= {sync_q[SYNC_N-2:0], hb_i};
      s_prev_q   <= s;
      cnt_q      <= cnt_d;
      fb_cnt_q   <= fb_cnt_d;
      feedback_q <= (fb_cnt_d != '0);
      err_q      <= err_d;
      code_q     <= code_d;
      err_cnt_q  <= err_cnt_d;
      fault_q    <= fault_d;
    end
  end

  assign feedback_o   = feedback_q;
  assign err_o        = err_q;
  assign fault_code_o = code_q;
  assign err_cnt_o    = err_cnt_q;
  assign fault_o      = fault_q;

endmodule

// File: tb/tb_safety_heartbeat_monitor.sv
// Bench for safety_heartbeat_monitor: timestamp-based reference model feeding an event scoreboard, plus per-cycle status checks.
module tb_safety_heartbeat_monitor;
  localparam int HIGH_MIN   = 90;
  localparam int HIGH_MAX   = 110;
  localparam int LOW_MIN    = 90;
  localparam int LOW_MAX    = 115;
  localparam int STARTUP_TO = 1024;
  localparam int FAIL_LIMIT = 3;
  localparam int FB_LEN     = 4;

  localparam int M_OFF = 0, M_WAIT = 1, M_HI = 2, M_LO = 3;
  localparam int EV_ERR = 0, EV_FB = 1;

  logic       clk_i = 1'b0;
  logic       rst_i, en_i, clear_i, hb_i;
  logic       feedback_o, err_o, fault_o;
  logic [2:0] fault_code_o;
  logic [3:0] err_cnt_o;

  safety_heartbeat_monitor #(
    .CNT_W(16), .HIGH_MIN(HIGH_MIN), .HIGH_MAX(HIGH_MAX), .LOW_MIN(LOW_MIN),
    .LOW_MAX(LOW_MAX), .STARTUP_TO(STARTUP_TO), .FAIL_LIMIT(FAIL_LIMIT), .FB_LEN(FB_LEN)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .clear_i(clear_i), .hb_i(hb_i),
    .feedback_o(feedback_o), .err_o(err_o), .fault_code_o(fault_code_o),
    .err_cnt_o(err_cnt_o), .fault_o(fault_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { int kind; int cyc; int code; int cnt; int fault; } ev_t;
  ev_t sb[$];

  int checks = 0;
  int errors = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: phases are measured as elapsed edges since the phase began.
  int cyc = 0;
  bit hist[$];
  int m_mode, m_t0, fb_end;
  int e_err, e_code, e_cnt, e_fault;

  task automatic model_step();
    bit s, sd, rise, fall, valid;
    int code, len;
    ev_t ev;
    cyc++;
    if (rst_i) begin
      hist = '{1'b0, 1'b0, 1'b0};
      m_mode = M_OFF; m_t0 = cyc; fb_end = cyc;
      e_err = 0; e_code = 0; e_cnt = 0; e_fault = 0;
      sb.delete();
      return;
    end
    // hist[k] holds hb sampled k+1 edges ago; the decision uses the 2- and 3-edge-old samples.
    s = hist[1]; sd = hist[2];
    rise = s && !sd; fall = !s && sd;
    code = 0; valid = 0; len = cyc - m_t0;
    case (m_mode)
      M_OFF:  if (en_i) begin m_mode = M_WAIT; m_t0 = cyc; end
      M_WAIT: if (rise) begin m_mode = M_HI; m_t0 = cyc; end
              else if (len - 1 == STARTUP_TO) code = 5;
      M_HI:   if (fall) begin
                if (len < HIGH_MIN) code = 1; else begin m_mode = M_LO; m_t0 = cyc; end
              end else if (len == HIGH_MAX) code = 2;
      M_LO:   if (rise) begin
                if (len < LOW_MIN) code = 3; else begin valid = 1; m_mode = M_HI; m_t0 = cyc; end
              end else if (len == LOW_MAX) code = 4;
      default: ;
    endcase
    e_err = 0;
    if (!en_i) begin
      m_mode = M_OFF; fb_end = cyc;
    end else if (clear_i) begin
      m_mode = M_WAIT; m_t0 = cyc;
    end else if (code != 0) begin
      e_err = 1; e_code = code;
      e_cnt = (e_cnt + 1 > FAIL_LIMIT) ? FAIL_LIMIT : e_cnt + 1;
      if (e_cnt == FAIL_LIMIT) e_fault = 1;
      m_mode = M_WAIT; m_t0 = cyc;
      ev = '{EV_ERR, cyc, e_code, e_cnt, e_fault};
      sb.push_back(ev);
    end else if (valid) begin
      e_cnt = 0; fb_end = cyc + FB_LEN;
      ev = '{EV_FB, cyc, 0, 0, 0};
      sb.push_back(ev);
    end
    if (clear_i) begin e_fault = 0; e_code = 0; e_cnt = 0; end
    hist.push_front(hb_i);
    void'(hist.pop_back());
  endtask

  always @(posedge clk_i) model_step();

  // Monitor: per-cycle status plus scoreboard pops on DUT-presented events.
  logic fb_prev = 1'b0;
  int   fb_rises = 0;
  int   err_seen = 0;
  always @(negedge clk_i) begin
    ev_t ev;
    chk("feedback_lvl", feedback_o, (cyc < fb_end) ? 1 : 0);
    chk("err_lvl", err_o, e_err);
    chk("code_lvl", fault_code_o, e_code);
    chk("cnt_lvl", err_cnt_o, e_cnt);
    chk("fault_lvl", fault_o, e_fault);
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      ev = sb.pop_front();
      chk("sb_missed_event_cyc", cyc, ev.cyc);
    end
    if (err_o === 1'b1) begin
      err_seen++;
      if (sb.size() == 0) chk("sb_unexpected_err", 1, 0);
      else begin
        ev = sb.pop_front();
        chk("sb_err_kind", ev.kind, EV_ERR);
        chk("sb_err_cyc", cyc, ev.cyc);
        chk("sb_err_code", fault_code_o, ev.code);
        chk("sb_err_cnt", err_cnt_o, ev.cnt);
        chk("sb_err_fault", fault_o, ev.fault);
      end
    end
    if (feedback_o === 1'b1 && fb_prev === 1'b0) begin
      fb_rises++;
      if (sb.size() == 0) chk("sb_unexpected_fb", 1, 0);
      else begin
        ev = sb.pop_front();
        chk("sb_fb_kind", ev.kind, EV_FB);
        chk("sb_fb_cyc", cyc, ev.cyc);
      end
    end
    fb_prev = feedback_o;
  end

  task automatic phase(input bit v, input int n);
    hb_i = v;
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic pulse_clear();
    clear_i = 1'b1;
    @(posedge clk_i); #1;
    clear_i = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

  initial begin
    int f0, e0, found;
    rst_i = 1'b1; en_i = 1'b0; clear_i = 1'b0; hb_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_feedback", feedback_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_code", fault_code_o, 0);
    chk("rst_cnt", err_cnt_o, 0);
    chk("rst_fault", fault_o, 0);
    rst_i = 1'b0;
    en_i  = 1'b1;
    phase(0, 5);

    // Nominal 100/100 periods
    f0 = fb_rises; e0 = err_seen;
    for (int i = 0; i < 5; i++) begin phase(1, 100); phase(0, 100); end
    chk("nom_fb_pulses", fb_rises - f0, 4);
    chk("nom_errs", err_seen - e0, 0);

    // Short high
    phase(1, 50); phase(0, 100);
    chk("short_code", fault_code_o, 1);
    chk("short_cnt", err_cnt_o, 1);
    for (int i = 0; i < 2; i++) begin phase(1, 100); phase(0, 100); end
    chk("short_cnt_after", err_cnt_o, 0);
    chk("short_code_kept", fault_code_o, 1);

    // High-phase boundaries
    e0 = err_seen;
    phase(1, HIGH_MAX); phase(0, 100);
    chk("hmax_legal", err_seen - e0, 0);
    phase(1, HIGH_MAX + 1); phase(0, 100);
    chk("hmax_plus1_code", fault_code_o, 2);
    chk("hmax_plus1_errs", err_seen - e0, 1);

    // Randomized periods with occasional clears
    for (int i = 0; i < 20; i++) begin
      int h, l;
      h = int'($urandom_range(80, 120));
      l = int'($urandom_range(80, 125));
      if ($urandom_range(0, 7) == 0) begin
        phase(1, h / 2); pulse_clear(); phase(1, h - h / 2);
      end else phase(1, h);
      phase(0, l);
    end

    // Stuck low after a fresh enable
    pulse_clear();
    for (int i = 0; i < 2; i++) begin phase(1, 100); phase(0, 100); end
    phase(1, 100); phase(0, 20);
    en_i = 1'b0; phase(0, 5);
    en_i = 1'b1;
    e0 = err_seen;
    phase(0, 3200);
    chk("stuck_errs", err_seen - e0, 3);
    chk("stuck_code", fault_code_o, 5);
    chk("stuck_cnt", err_cnt_o, FAIL_LIMIT);
    chk("stuck_fault", fault_o, 1);

    // Clear lands in the same cycle as a long-low error
    phase(1, 100);
    phase(0, LOW_MAX + 1);
    clear_i = 1'b1;
    @(posedge clk_i); #1;
    clear_i = 1'b0;
    chk("clr_err", err_o, 0);
    chk("clr_fault", fault_o, 0);
    chk("clr_cnt", err_cnt_o, 0);
    chk("clr_code", fault_code_o, 0);

    // Re-fault, then disable during a feedback pulse
    phase(0, 50);
    for (int i = 0; i < 3; i++) begin phase(1, 50); phase(0, 100); end
    chk("refault", fault_o, 1);
    phase(1, 100); phase(0, 100);
    hb_i = 1'b1;
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      @(posedge clk_i); #1;
      if (feedback_o === 1'b1) found = 1;
    end
    chk("dis_fb_seen", found, 1);
    en_i = 1'b0;
    @(posedge clk_i); #1;
    chk("dis_fb_off", feedback_o, 0);
    chk("dis_fault_kept", fault_o, 1);

    // Reset while faulted
    en_i = 1'b1;
    phase(1, 20);
    chk("pre_rst_fault", fault_o, 1);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    chk("mrst_feedback", feedback_o, 0);
    chk("mrst_err", err_o, 0);
    chk("mrst_code", fault_code_o, 0);
    chk("mrst_cnt", err_cnt_o, 0);
    chk("mrst_fault", fault_o, 0);
    rst_i = 1'b0;
    phase(0, 10);

    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
